// File: rtl/regfile_pkg.sv
// Shared defaults and address type for the multi-port register file.
package regfile_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_REGS_DEF   = 32;
  localparam int AW             = $clog2(NUM_REGS_DEF);

  typedef logic [AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, released by writeback,
// set by decode allocation, cleared wholesale by flush; registered popcount.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_WR   = 2,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_WR-1:0]         wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0] wr_addr_i,
  input  logic                      alloc_en_i,
  input  logic [AW-1:0]             alloc_addr_i,
  input  logic                      flush_i,
  output logic [NUM_REGS-1:0]       busy_o,
  output logic [AW:0]               busy_cnt_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [AW:0]         cnt_q, cnt_d;

  // Release first, then alloc on top: a same-cycle alloc names a younger producer.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w]) busy_d[wr_addr_i[w]] = 1'b0;
    end
    if (flush_i) begin
      busy_d = '0;
    end else if (alloc_en_i) begin
      busy_d[alloc_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;

    cnt_d = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file (x0 hardwired to zero) with per-read busy status.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int NUM_RD     = 3,
  parameter int NUM_WR     = 2,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_RD-1:0][AW-1:0]         rd_addr_i,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data_o,
  output logic [NUM_RD-1:0]                 rd_busy_o,
  input  logic [NUM_WR-1:0]                 wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0]         wr_addr_i,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_data_i,
  input  logic                              alloc_en_i,
  input  logic [AW-1:0]                     alloc_addr_i,
  input  logic                              flush_i,
  output logic [AW:0]                       busy_cnt_o
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR)
  ) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .alloc_en_i   (alloc_en_i),
    .alloc_addr_i (alloc_addr_i),
    .flush_i      (flush_i),
    .busy_o       (busy),
    .busy_cnt_o   (busy_cnt_o)
  );

  // Later ports overwrite earlier ones, so the highest-index port wins a collision.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w] && wr_addr_i[w] != '0) regs_d[wr_addr_i[w]] = wr_data_i[w];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_addr_i[k] != '0) begin
        rd_data_o[k] = regs_q[rd_addr_i[k]];
        rd_busy_o[k] = busy[rd_addr_i[k]];
      end
`ifdef REGFILE_BYPASS_EN
      // A value arriving this cycle satisfies its reader regardless of the busy bit.
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && wr_addr_i[w] != '0 && wr_addr_i[w] == rd_addr_i[k]) begin
          rd_data_o[k] = wr_data_i[w];
          rd_busy_o[k] = 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vectors with literal expectations plus a
// spec-level model compared on every falling edge.
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 3;
  localparam int NWR = 2;
  localparam int AW  = 5;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][DW-1:0]   rd_data;
  logic [NRD-1:0]           rd_busy;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][DW-1:0]   wr_data;
  logic                     alloc_en;
  logic [AW-1:0]            alloc_addr;
  logic                     flush;
  logic [AW:0]              busy_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  regfile_mp #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .rd_busy_o    (rd_busy),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .alloc_en_i   (alloc_en),
    .alloc_addr_i (alloc_addr),
    .flush_i      (flush),
    .busy_cnt_o   (busy_cnt)
  );

  always #5 clk = ~clk;

  // Architectural state as the specification describes it.
  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];
  int            m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NR; r++) begin m_regs[r] = '0; m_busy[r] = 0; end
      m_cnt = 0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && wr_addr[w] != 0) begin
          m_regs[wr_addr[w]] = wr_data[w];
          m_busy[wr_addr[w]] = 0;
        end
      end
      if (flush) for (int r = 0; r < NR; r++) m_busy[r] = 0;
      else if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1;
      m_cnt = 0;
      for (int r = 0; r < NR; r++) m_cnt += int'(m_busy[r]);
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NRD; k++) begin
      logic [DW-1:0] ed;
      logic          eb;
      ed = (rd_addr[k] == 0) ? '0 : m_regs[rd_addr[k]];
      eb = (rd_addr[k] == 0) ? 1'b0 : m_busy[rd_addr[k]];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && wr_addr[w] != 0 && wr_addr[w] == rd_addr[k]) begin
          ed = wr_data[w];
          eb = 1'b0;
        end
      end
`endif
      chk($sformatf("model_rd_data[%0d]", k), rd_data[k], ed);
      chk($sformatf("model_rd_busy[%0d]", k), {31'b0, rd_busy[k]}, {31'b0, eb});
    end
    chk("model_busy_cnt", {26'b0, busy_cnt}, m_cnt[DW-1:0]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0; alloc_en = 1'b0; flush = 1'b0;
  endtask

  task automatic rd_all(input logic [AW-1:0] a);
    for (int k = 0; k < NRD; k++) rd_addr[k] = a;
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [DW-1:0] d, input logic b);
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("%s_data[%0d]", nm, k), rd_data[k], d);
      chk($sformatf("%s_busy[%0d]", nm, k), {31'b0, rd_busy[k]}, {31'b0, b});
    end
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0; alloc_addr = '0;
    idle();
    tick(); tick();

    for (int a = 0; a < NR; a++) begin
      rd_all(a[AW-1:0]);
      chk_all($sformatf("reset_x%0d", a), 32'h0, 1'b0);
    end
    chk("reset_cnt", {26'b0, busy_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
    tick(); idle();
    rd_all(5'd5);
    chk_all("wr_x5", 32'hDEADBEEF, 1'b0);

    wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'h1;
    tick(); idle();
    rd_all(5'd0);
    chk_all("wr_x0", 32'h0, 1'b0);

    wr_en = 2'b11; wr_addr[0] = 5'd7; wr_data[0] = 32'h11; wr_addr[1] = 5'd7; wr_data[1] = 32'h22;
    tick(); idle();
    rd_all(5'd7);
    chk_all("collide_x7", 32'h22, 1'b0);

    alloc_en = 1'b1; alloc_addr = 5'd3;
    tick(); idle();
    rd_all(5'd3);
    chk_all("alloc_x3", 32'h0, 1'b1);
    chk("alloc_x3_cnt", {26'b0, busy_cnt}, 32'd1);

    alloc_en = 1'b1; alloc_addr = 5'd3; wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h33;
    tick(); idle();
    #1;
    chk_all("alloc_wr_x3", 32'h33, 1'b1);
    chk("alloc_wr_x3_cnt", {26'b0, busy_cnt}, 32'd1);

    wr_en = 2'b10; wr_addr[1] = 5'd3; wr_data[1] = 32'h44;
    tick(); idle();
    #1;
    chk_all("release_x3", 32'h44, 1'b0);
    chk("release_x3_cnt", {26'b0, busy_cnt}, 32'd0);

    alloc_en = 1'b1; alloc_addr = 5'd1; tick();
    alloc_addr = 5'd2; tick();
    alloc_addr = 5'd4; tick();
    idle();
    chk("three_alloc_cnt", {26'b0, busy_cnt}, 32'd3);
    rd_addr[0] = 5'd1; rd_addr[1] = 5'd2; rd_addr[2] = 5'd4; #1;
    chk("three_alloc_busy", {29'b0, rd_busy}, 32'h7);
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd9;
    tick(); idle();
    chk("flush_cnt", {26'b0, busy_cnt}, 32'd0);
    rd_addr[0] = 5'd9; #1;
    chk("flush_busy", {29'b0, rd_busy}, 32'h0);

    rd_all(5'd6);
    wr_en = 2'b01; wr_addr[0] = 5'd6; wr_data[0] = 32'hABCD; #1;
`ifdef REGFILE_BYPASS_EN
    chk_all("same_cycle_x6", 32'hABCD, 1'b0);
`else
    chk_all("same_cycle_x6", 32'h0, 1'b0);
`endif
    tick(); idle(); #1;
    chk_all("after_x6", 32'hABCD, 1'b0);

    alloc_en = 1'b1; alloc_addr = 5'd6;
    tick(); idle();
    wr_en = 2'b10; wr_addr[1] = 5'd6; wr_data[1] = 32'h6666; #1;
`ifdef REGFILE_BYPASS_EN
    chk_all("busy_fwd_x6", 32'h6666, 1'b0);
`else
    chk_all("busy_fwd_x6", 32'hABCD, 1'b1);
`endif
    tick(); idle();

    for (int i = 0; i < 60; i++) begin
      wr_en      = 2'($urandom_range(0, 3));
      wr_addr[0] = 5'($urandom_range(0, 7));
      wr_addr[1] = 5'($urandom_range(0, 7));
      wr_data[0] = $urandom;
      wr_data[1] = $urandom;
      alloc_en   = ($urandom_range(0, 2) != 0);
      alloc_addr = 5'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < NRD; k++) rd_addr[k] = 5'($urandom_range(0, 7));
      tick();
    end
    idle();

    alloc_en = 1'b1; alloc_addr = 5'd10; wr_en = 2'b01; wr_addr[0] = 5'd10; wr_data[0] = 32'h1234;
    tick(); idle();
    chk("pre_reset_cnt_nonzero", {31'b0, busy_cnt != 0}, 32'd1);
    #2 rst_n = 1'b0; #1;
    rd_all(5'd10);
    chk_all("async_reset_x10", 32'h0, 1'b0);
    chk("async_reset_cnt", {26'b0, busy_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with an integrated pending-write scoreboard, the successor to the single-write, two-read core register file. Sits between decode (read/allocate) and writeback (write/release) and serves dual-issue or extra-operand configurations from one block. Register 0 is hardwired to zero. Each read port also reports whether its register still awaits an in-flight producer.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- NUM_REGS, 32, architectural registers, power of two, ≥ 2
- NUM_RD, 3, read ports, ≥ 1
- NUM_WR, 2, write ports, ≥ 1
- AW, $clog2(NUM_REGS), address width (derived, not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr_i  in  [NUM_RD-1:0][AW-1:0]  read addresses
- rd_data_o  out  [NUM_RD-1:0][DATA_WIDTH-1:0]  read data, combinational
- rd_busy_o  out  [NUM_RD-1:0]  addressed register has a pending producer
- wr_en_i  in  [NUM_WR-1:0]  write enables, from writeback
- wr_addr_i  in  [NUM_WR-1:0][AW-1:0]  write addresses
- wr_data_i  in  [NUM_WR-1:0][DATA_WIDTH-1:0]  write data
- alloc_en_i  in  1  decode issues an instruction that will write alloc_addr_i
- alloc_addr_i  in  [AW-1:0]  destination being allocated
- flush_i  in  1  pipeline flush, drops all pending producers
- busy_cnt_o  out  [AW:0]  number of busy registers, registered

## Operation
- Storage: NUM_REGS×DATA_WIDTH flops plus NUM_REGS busy bits; entry 0 never written, never busy, always reads 0.
- Read: rd_data_o[k] = regs[rd_addr_i[k]] (0 for address 0); rd_busy_o[k] = busy[rd_addr_i[k]]. Pure combinational.
- Write: each port with wr_en_i set and address ≠ 0 writes on the edge. Two ports hitting the same address: highest-index port wins, data and busy release alike.
- Busy release: a write to register r clears busy[r].
- Busy set: alloc_en_i with alloc_addr_i ≠ 0 sets busy[alloc_addr_i]. Alloc and write to the same register in one cycle: alloc wins (busy stays 1; the new producer is younger); data is still written.
- Flush: flush_i clears every busy bit; any alloc in that cycle is discarded; writes in that cycle still update data.
- busy_cnt_o: popcount of the busy vector after the edge, held in a register and updated each cycle; range 0..NUM_REGS-1.
- Writes to already-clear registers and allocs to already-busy registers are legal (idempotent).

## Timing
- Reset (asynchronous assert, synchronous deassert in the system): all regs 0, all busy 0, busy_cnt_o 0; rd_data_o therefore 0 and rd_busy_o 0 for all addresses.
- Reset mid-operation discards all pending writes and allocs immediately.
- Write-to-read latency 1 cycle without bypass: data written on edge N is visible on reads from N+1.
- Alloc-to-busy latency 1 cycle: rd_busy_o rises in the cycle after alloc_en_i.
- busy_cnt_o lags the busy vector by 0 cycles relative to its edge (both update on the same edge).
- No handshakes; every input is sampled on every edge.

## Configuration
- REGFILE_BYPASS_EN defined: a read whose address matches an enabled same-cycle write port (address ≠ 0) returns that port's wr_data_i (highest-index match) and reports rd_busy_o = 0 unless busy is set and an alloc to that address is also... no: rd_busy_o = 0 for matching writes regardless of the registered busy bit.
- Not defined: reads return stored value and stored busy bit only; same-cycle writes are invisible until the next cycle.
- Alloc never bypasses in either mode.

## Structure
- Package regfile_pkg: default DATA_WIDTH/NUM_REGS constants, and a reg_addr_t typedef parameterised via localparam AW.
- Sub-module regfile_scoreboard: busy vector, alloc/release/flush priority, popcount register; the data array and read muxes stay in regfile_mp.

## Test plan
- Reset, then read all addresses on all ports -> rd_data_o 0, rd_busy_o 0, busy_cnt_o 0.
- Write 0xDEADBEEF to x5 on port 0; next cycle read x5 on all ports -> 0xDEADBEEF; write 0x1 to x0 -> x0 still reads 0.
- Ports 0 and 1 write x7 with 0x11 and 0x22 in the same cycle -> x7 reads 0x22.
- Alloc x3 -> next cycle rd_busy_o 1, busy_cnt_o 1; write x3 with alloc x3 in one cycle -> busy stays 1; write alone -> busy 0, count 0.
- Alloc x1, x2, x4 over three cycles, then flush_i together with alloc x9 -> all busy 0, busy_cnt_o 0, x9 not busy.
- With REGFILE_BYPASS_EN, write x6 = 0xABCD and read x6 in the same cycle -> rd_data_o 0xABCD, rd_busy_o 0; without it -> old value.
